// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter.
// Holds default widths, memory op codes and the arbiter state encoding.
package dmem_arbiter_pkg;

    localparam int DMEM_ADDR_WIDTH  = 8;
    localparam int DMEM_DATA_WIDTH  = 32;
    localparam int DMEM_MEM_OP_BITS = 2;

    localparam logic [1:0] MEM_OP_NOP   = 2'b00;
    localparam logic [1:0] MEM_OP_READ  = 2'b01;
    localparam logic [1:0] MEM_OP_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side req/gnt/rvalid bundle for one arbiter port.
// master: requester drives req/op/addr/wdata; slave: arbiter drives gnt/rvalid/rdata.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH  = dmem_arbiter_pkg::DMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH  = dmem_arbiter_pkg::DMEM_DATA_WIDTH,
    parameter int MEM_OP_BITS = dmem_arbiter_pkg::DMEM_MEM_OP_BITS
);

    logic                   req;
    logic [MEM_OP_BITS-1:0] op;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0]  wdata;
    logic                   gnt;
    logic                   rvalid;
    logic [DATA_WIDTH-1:0]  rdata;

    modport master (
        output req,
        output op,
        output addr,
        output wdata,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  op,
        input  addr,
        input  wdata,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick.
// Ports: req0/req1 requests, last_winner (1 = port 1); winner (1 = port 1), any_req.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_winner,
    output logic winner,
    output logic any_req
);

    always_comb begin
        any_req = req0 | req1;
        // Contention goes to whichever port did not win last time.
        winner  = (req0 && req1) ? ~last_winner : req1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sharing of the single-port data RAM between two requesters.
// Ports: clk/reset, p0/p1 request bundles, done_in, RAM bus, ram_complete, busy.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = DMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DMEM_DATA_WIDTH,
    parameter int MEM_OP_BITS = DMEM_MEM_OP_BITS
) (
    input  logic                   clk,
    input  logic                   reset,
    dmem_arbiter_if.slave          p0,
    dmem_arbiter_if.slave          p1,
    input  logic                   done_in,
    output logic [MEM_OP_BITS-1:0] ram_mem_op,
    output logic [ADDR_WIDTH-1:0]  ram_address,
    output logic [DATA_WIDTH-1:0]  ram_write_data,
    input  logic [DATA_WIDTH-1:0]  ram_read_data,
    output logic                   ram_complete,
    output logic                   busy
);

    localparam logic [MEM_OP_BITS-1:0] OP_NOP =
        MEM_OP_BITS'(MEM_OP_NOP);
    localparam logic [MEM_OP_BITS-1:0] OP_READ =
        MEM_OP_BITS'(MEM_OP_READ);
    localparam logic [MEM_OP_BITS-1:0] OP_WRITE =
        MEM_OP_BITS'(MEM_OP_WRITE);

    arb_state_e state;
    arb_state_e state_n;

    logic                   last_winner;
    logic                   dump_pending;
    logic [MEM_OP_BITS-1:0] op_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic                   win_q;
    logic                   gnt0_q;
    logic                   gnt1_q;
    logic                   rvalid0_q;
    logic                   rvalid1_q;
    logic [DATA_WIDTH-1:0]  rdata0_q;
    logic [DATA_WIDTH-1:0]  rdata1_q;

    logic winner;
    logic any_req;
    logic arb_point;
    logic take;
    logic op_ok;

    rr_arb2 u_rr_arb2 (
        .req0        (p0.req),
        .req1        (p1.req),
        .last_winner (last_winner),
        .winner      (winner),
        .any_req     (any_req)
    );

    always_comb begin
        state_n   = state;
        arb_point = 1'b0;
        unique case (state)
            ARB_IDLE:   arb_point = 1'b1;
            ARB_ACCESS: state_n   = ARB_RESP;
            ARB_RESP:   arb_point = 1'b1;
            default:    state_n   = ARB_IDLE;
        endcase
        take = arb_point & any_req;
        if (arb_point) begin
            state_n = take ? ARB_ACCESS : ARB_IDLE;
        end
    end

    assign op_ok = (op_q == OP_READ) || (op_q == OP_WRITE);

    // Gating with reset keeps a write in flight from landing
    // on the RAM edge that also resets the arbiter.
    always_comb begin
        ram_mem_op = OP_NOP;
        if (state == ARB_ACCESS && op_ok && !reset) begin
            ram_mem_op = op_q;
        end
    end

    assign ram_address    = addr_q;
    assign ram_write_data = wdata_q;
    assign busy           = (state != ARB_IDLE);
    assign ram_complete   = (state == ARB_IDLE) && dump_pending &&
                            !any_req && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ARB_IDLE;
            last_winner  <= 1'b1;
            dump_pending <= 1'b0;
            op_q         <= OP_NOP;
            addr_q       <= '0;
            wdata_q      <= '0;
            win_q        <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state     <= state_n;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            if (take) begin
                op_q        <= winner ? p1.op    : p0.op;
                addr_q      <= winner ? p1.addr  : p0.addr;
                wdata_q     <= winner ? p1.wdata : p0.wdata;
                win_q       <= winner;
                last_winner <= winner;
                gnt0_q      <= ~winner;
                gnt1_q      <= winner;
            end
            if (state == ARB_ACCESS) begin
                rvalid0_q <= ~win_q;
                rvalid1_q <= win_q;
                if (op_q == OP_READ) begin
                    if (win_q) begin
                        rdata1_q <= ram_read_data;
                    end else begin
                        rdata0_q <= ram_read_data;
                    end
                end
            end
            // A fresh done_in re-arms even on the cycle the dump fires.
            dump_pending <= done_in | (dump_pending & ~ram_complete);
        end
    end

    assign p0.gnt    = gnt0_q;
    assign p1.gnt    = gnt1_q;
    assign p0.rvalid = rvalid0_q;
    assign p1.rvalid = rvalid1_q;
    assign p0.rdata  = rdata0_q;
    assign p1.rdata  = rdata1_q;

endmodule
